// File: rtl/zuss_lsu.sv
// zuss_lsu: single-outstanding load/store unit in front of the ZUSS data memory.
// Converts byte/half/word requests into aligned word accesses and extends load results.
module zuss_lsu #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  cnt;

  logic        accept;
  logic        illegal;
  logic [3:0]  lane_we;
  logic [31:0] lane_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'd1, 3'd5:       illegal = req_addr[0];
      3'd2:             illegal = (req_addr[1:0] != 2'b00);
      3'd3, 3'd6, 3'd7: illegal = 1'b1;
      default:          illegal = 1'b0;
    endcase
    if (req_we && (req_funct3 > 3'd2)) illegal = 1'b1;
  end

  // Store data is replicated across all lanes; the byte enables pick the live ones.
  always_comb begin
    lane_we   = 4'b0000;
    lane_data = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        lane_we   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_we   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_we   = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  assign load_byte = mem_out[{addr_lo_q, 3'b000} +: 8];
  assign load_half = addr_lo_q[1] ? mem_out[31:16] : mem_out[15:0];

  always_comb begin
    load_data = mem_out;
    case (funct3_q)
      3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
      3'd4:    load_data = {24'h000000, load_byte};
      3'd1:    load_data = {{16{load_half[15]}}, load_half};
      3'd5:    load_data = {16'h0000, load_half};
      default: load_data = mem_out;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? RESP : ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (cnt == 2'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      cnt       <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state_nxt == RESP);
      rsp_err   <= accept && illegal;
      rsp_rdata <= ((state == WAIT) && (cnt == 2'd1)) ? load_data : '0;
      mem_we    <= (accept && !illegal && req_we) ? lane_we : 4'b0000;

      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        // Rejected requests leave the memory-side bus untouched.
        if (!illegal) begin
          mem_addr <= {req_addr[31:2], 2'b00};
          if (req_we) mem_data <= lane_data;
        end
      end

      if (state == ISSUE)     cnt <= 2'(MEM_LATENCY);
      else if (state == WAIT) cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_zuss_lsu.sv
// Bench for zuss_lsu: two instances (latency 1 and 3), a behavioural data memory,
// and a byte-level reference model of memory contents and expected responses.
module tb_zuss_lsu;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [3:0]  mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_data  [2];
  logic [31:0] mem_out   [2];

  always #5 clk = ~clk;

  zuss_lsu #(.MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_data(mem_data[0]), .mem_out(mem_out[0])
  );

  zuss_lsu #(.MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_data(mem_data[1]), .mem_out(mem_out[1])
  );

  // Data memory per instance: byte-enabled writes, reads delayed through a 3-deep pipe.
  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][3];
  logic        mem_clear;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clear) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= '0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[d][b]) mem[d][mem_addr[d][9:2]][8*b +: 8] <= mem_data[d][8*b +: 8];
      end
      pipe[d][0] <= mem[d][mem_addr[d][9:2]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  assign mem_out[0] = pipe[0][0];
  assign mem_out[1] = pipe[1][2];

  // Reference model state and bookkeeping.
  logic [31:0] ref_mem [2][256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          txn_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_illegal(input txn_t t);
    if (t.we && t.f3 > 2) return 1'b1;
    if (!t.we && (t.f3 == 3 || t.f3 == 6 || t.f3 == 7)) return 1'b1;
    if ((t.f3 == 1 || t.f3 == 5) && (t.addr % 2 != 0)) return 1'b1;
    if (t.f3 == 2 && (t.addr % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_we(input txn_t t);
    logic [3:0] w;
    int lane;
    w    = 4'b0000;
    lane = int'(t.addr % 4);
    for (int i = 0; i < size_of(t.f3); i++) w[lane + i] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] exp_data(input txn_t t);
    logic [31:0] v;
    int nb;
    nb = size_of(t.f3);
    for (int i = 0; i < 4; i++) v[8*i +: 8] = t.wdata[8*(i % nb) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] load_value(input txn_t t, input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] mask;
    int nb;
    nb = size_of(t.f3);
    if (nb == 4) return w;
    v    = w >> (8 * int'(t.addr % 4));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (t.f3 < 4 && v[8*nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.f3    = 3'($urandom_range(0, 7));
    if (t.we && $urandom_range(0, 3) != 0) t.f3 = 3'($urandom_range(0, 2));
    t.addr  = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
    t.wdata = $urandom;
    return t;
  endfunction

  function automatic txn_t mk(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  task automatic drive(input int d, input bit v, input txn_t t);
    req_valid[d]  = v;
    req_we[d]     = t.we;
    req_funct3[d] = t.f3;
    req_addr[d]   = t.addr;
    req_wdata[d]  = t.wdata;
  endtask

  // One complete transaction from the IDLE cycle through the IDLE cycle after RESP.
  task automatic run_txn(input int d, input txn_t t, input bit has_next, input txn_t nxt);
    string p;
    int    lat;
    int    idx;
    int    lane;
    p    = $sformatf("d%0d#%0d", d, txn_no);
    lat  = (d == 0) ? 1 : 3;
    idx  = int'(t.addr[9:2]);
    lane = int'(t.addr % 4);
    txn_no++;

    drive(d, 1'b1, t);
    check({p, ".ready_idle"}, req_ready[d], 1);
    tick();
    if (has_next) drive(d, 1'b1, nxt);
    else          drive(d, 1'b0, rand_txn());

    if (is_illegal(t)) begin
      check({p, ".err_valid"}, rsp_valid[d], 1);
      check({p, ".err_flag"},  rsp_err[d], 1);
      check({p, ".err_rdata"}, rsp_rdata[d], 0);
      check({p, ".err_mem_we"}, mem_we[d], 0);
      check({p, ".err_ready"}, req_ready[d], 0);
    end else begin
      check({p, ".issue_valid"}, rsp_valid[d], 0);
      check({p, ".issue_ready"}, req_ready[d], 0);
      check({p, ".issue_addr"},  mem_addr[d], t.addr & 32'hFFFF_FFFC);
      if (t.we) begin
        check({p, ".st_we"},   mem_we[d], exp_we(t));
        check({p, ".st_data"}, mem_data[d], exp_data(t));
        for (int i = 0; i < size_of(t.f3); i++)
          ref_mem[d][idx][8*(lane + i) +: 8] = t.wdata[8*i +: 8];
        tick();
        check({p, ".st_rsp_valid"}, rsp_valid[d], 1);
        check({p, ".st_rsp_err"},   rsp_err[d], 0);
        check({p, ".st_rsp_rdata"}, rsp_rdata[d], 0);
        check({p, ".st_rsp_we"},    mem_we[d], 0);
      end else begin
        check({p, ".ld_issue_we"}, mem_we[d], 0);
        for (int k = 2; k <= lat + 1; k++) begin
          tick();
          check({p, ".wait_valid"}, rsp_valid[d], 0);
          check({p, ".wait_we"},    mem_we[d], 0);
          check({p, ".wait_addr"},  mem_addr[d], t.addr & 32'hFFFF_FFFC);
          check({p, ".wait_ready"}, req_ready[d], 0);
        end
        tick();
        check({p, ".ld_rsp_valid"}, rsp_valid[d], 1);
        check({p, ".ld_rsp_err"},   rsp_err[d], 0);
        check({p, ".ld_rsp_rdata"}, rsp_rdata[d], load_value(t, ref_mem[d][idx]));
      end
    end
    tick();
    check({p, ".done_valid"}, rsp_valid[d], 0);
    check({p, ".done_ready"}, req_ready[d], 1);
  endtask

  txn_t none;

  initial begin
    none = mk(1'b0, 3'd0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      drive(d, 1'b0, none);
      for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
    end
    mem_clear = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d.rst_ready", d), req_ready[d], 1);
      check($sformatf("d%0d.rst_valid", d), rsp_valid[d], 0);
      check($sformatf("d%0d.rst_rdata", d), rsp_rdata[d], 0);
      check($sformatf("d%0d.rst_err", d),   rsp_err[d], 0);
      check($sformatf("d%0d.rst_we", d),    mem_we[d], 0);
      check($sformatf("d%0d.rst_addr", d),  mem_addr[d], 0);
      check($sformatf("d%0d.rst_data", d),  mem_data[d], 0);
      rst[d] = 1'b0;
    end
    mem_clear = 1'b0;
    tick();

    // Directed cases on the latency-1 instance.
    run_txn(0, mk(1'b1, 3'd2, 32'd500,  32'd250),        1'b0, none);
    run_txn(0, mk(1'b1, 3'd0, 32'd1002, 32'h001F_0025),  1'b0, none);
    run_txn(0, mk(1'b1, 3'd1, 32'd1002, 32'h0000_0200),  1'b0, none);
    run_txn(0, mk(1'b1, 3'd2, 32'd1000, 32'h0080_0000),  1'b0, none);
    run_txn(0, mk(1'b0, 3'd0, 32'd1002, 32'h0),          1'b0, none);
    run_txn(0, mk(1'b0, 3'd4, 32'd1002, 32'h0),          1'b0, none);
    run_txn(0, mk(1'b0, 3'd1, 32'd1001, 32'h0),          1'b0, none);
    run_txn(0, mk(1'b0, 3'd2, 32'd1002, 32'h0),          1'b0, none);
    run_txn(0, mk(1'b0, 3'd3, 32'd1000, 32'h0),          1'b0, none);
    run_txn(0, mk(1'b1, 3'd4, 32'd1000, 32'hDEAD_BEEF),  1'b0, none);
    run_txn(0, mk(1'b0, 3'd2, 32'd1000, 32'h0),          1'b0, none);

    // Latency-3 instance: LHU with a second request held through the busy window.
    run_txn(1, mk(1'b1, 3'd2, 32'd1000, 32'h8001_ABCD),  1'b0, none);
    run_txn(1, mk(1'b0, 3'd5, 32'd1002, 32'h0),          1'b1, mk(1'b0, 3'd2, 32'd1000, 32'h0));
    run_txn(1, mk(1'b0, 3'd2, 32'd1000, 32'h0),          1'b0, none);

    // Reset arriving in the first WAIT cycle drops the load.
    drive(1, 1'b1, mk(1'b0, 3'd5, 32'd1002, 32'h0));
    tick();
    drive(1, 1'b0, none);
    tick();
    check("rstw.in_wait_ready", req_ready[1], 0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check("rstw.ready", req_ready[1], 1);
    check("rstw.valid", rsp_valid[1], 0);
    check("rstw.rdata", rsp_rdata[1], 0);
    check("rstw.err",   rsp_err[1], 0);
    check("rstw.we",    mem_we[1], 0);
    check("rstw.addr",  mem_addr[1], 0);
    check("rstw.data",  mem_data[1], 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstw.quiet_valid", rsp_valid[1], 0);
      check("rstw.quiet_ready", req_ready[1], 1);
    end
    run_txn(1, mk(1'b0, 3'd1, 32'd1002, 32'h0), 1'b0, none);

    // Randomized traffic on both instances.
    for (int n = 0; n < 120; n++) begin
      int d;
      d = n % 2;
      run_txn(d, rand_txn(), 1'b0, none);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("gap.valid", rsp_valid[d], 0);
        check("gap.ready", req_ready[d], 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
